// File: rtl/reg_file_sweep_pkg.sv
// Shared types and default sizes for the sweep-cleared register file.
package reg_file_sweep_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// Clear-sweep FSM, sweep pointer and write-commit qualification.
module reg_file_sweep_ctrl
  import reg_file_sweep_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              clr,
  output logic              busy,
  output logic              commit,
  output logic              wr_drop,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] ptr
);

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      case (state)
        SWEEP: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= IDLE;
        end
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        default: begin
          state <= SWEEP;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == SWEEP);
  assign sweep_we = busy && rst_n;

  // clr and reset both pre-empt a same-cycle write; entry 0 is read-only when hard-wired.
  always_comb begin
    commit = (state == IDLE) && wr && !clr && rst_n;
    if (ZERO_REG != 0 && waddr == '0) commit = 1'b0;
  end

  assign wr_drop = wr && !commit;

endmodule

// File: rtl/reg_file_sweep.sv
// Parametrised 2-read / 1-write register file with sequential clear sweep.
module reg_file_sweep
  import reg_file_sweep_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] Din,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic              clr,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              commit;
  logic              sweep_we;
  logic [ADDR_W-1:0] ptr;

  reg_file_sweep_ctrl #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .waddr    (Rw),
    .clr      (clr),
    .busy     (busy),
    .commit   (commit),
    .wr_drop  (wr_drop),
    .sweep_we (sweep_we),
    .ptr      (ptr)
  );

  // Single write port, no reset: the sweep shares it so the array maps to distributed RAM.
  always_ff @(posedge clk) begin
    if (sweep_we)    mem[ptr] <= '0;
    else if (commit) mem[Rw]  <= Din;
  end

  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] res;
    res = word;
    if (busy)                                   res = '0;
    else if (ZERO_REG != 0 && addr == '0)       res = '0;
    else if (BYPASS != 0 && commit && addr == Rw) res = Din;
    return res;
  endfunction

  always_comb begin
    OUT1 = read_sel(R1, mem[R1]);
    OUT2 = read_sel(R2, mem[R2]);
  end

endmodule

// File: tb/tb_reg_file_sweep.sv
// Scoreboard bench: three configurations share stimulus, checked against an array model.
module tb_reg_file_sweep;

  localparam int NC    = 3;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n, wr, clr;
  logic [3:0] Rw, R1, R2;
  logic [7:0] Din;

  logic [NC-1:0][7:0] o1, o2;
  logic [NC-1:0]      busy, drop;

  // config 0: defaults, 1: no bypass, 2: hard-wired zero register
  bit byp [NC] = '{1'b1, 1'b0, 1'b1};
  bit zr  [NC] = '{1'b0, 1'b0, 1'b1};

  reg_file_sweep #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .wr(wr), .Rw(Rw), .Din(Din), .R1(R1), .R2(R2), .clr(clr),
    .OUT1(o1[0]), .OUT2(o2[0]), .busy(busy[0]), .wr_drop(drop[0]));
  reg_file_sweep #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wr(wr), .Rw(Rw), .Din(Din), .R1(R1), .R2(R2), .clr(clr),
    .OUT1(o1[1]), .OUT2(o2[1]), .busy(busy[1]), .wr_drop(drop[1]));
  reg_file_sweep #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_zero (
    .clk(clk), .rst_n(rst_n), .wr(wr), .Rw(Rw), .Din(Din), .R1(R1), .R2(R2), .clr(clr),
    .OUT1(o1[2]), .OUT2(o2[2]), .busy(busy[2]), .wr_drop(drop[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NC-1:0][7:0] o1;
    logic [NC-1:0][7:0] o2;
    logic [NC-1:0]      busy;
    logic [NC-1:0]      drop;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: contents plus number of sweep edges still outstanding.
  logic [7:0] mem [NC][DEPTH];
  int         left;

  function automatic logic commit_f(int c);
    return (left == 0) && wr && !clr && rst_n && !(zr[c] && Rw == 4'd0);
  endfunction

  function automatic logic [7:0] rd_f(int c, logic [3:0] a);
    if (left > 0)                          return 8'h00;
    if (zr[c] && a == 4'd0)                return 8'h00;
    if (byp[c] && commit_f(c) && a == Rw)  return Din;
    return mem[c][a];
  endfunction

  task automatic model_edge();
    if (!rst_n || (left == 0 && clr)) begin
      left = DEPTH;
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < DEPTH; i++) mem[c][i] = 8'h00;
    end else if (left > 0) begin
      left--;
    end else begin
      for (int c = 0; c < NC; c++)
        if (commit_f(c)) mem[c][Rw] = Din;
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [3:0] wa, input logic [7:0] d,
                     input logic [3:0] a1, input logic [3:0] a2, input logic c, input bit chk = 1'b1);
    exp_t e;
    rst_n = r; wr = w; Rw = wa; Din = d; R1 = a1; R2 = a2; clr = c;
    if (chk) begin
      for (int k = 0; k < NC; k++) begin
        e.o1[k]   = rd_f(k, a1);
        e.o2[k]   = rd_f(k, a2);
        e.busy[k] = (left > 0);
        e.drop[k] = w && !commit_f(k);
      end
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input int c, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[cfg%0d] got %h want %h at %0t", name, c, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int c = 0; c < NC; c++) begin
        check("busy",    c, {7'd0, busy[c]}, {7'd0, e.busy[c]});
        check("wr_drop", c, {7'd0, drop[c]}, {7'd0, e.drop[c]});
        check("OUT1",    c, o1[c], e.o1[c]);
        check("OUT2",    c, o2[c], e.o2[c]);
      end
    end
  end

  initial begin
    left = DEPTH;
    // reset sweep: first edge has undefined outputs before it, so it is not checked
    cyc(1'b0, 1'b0, 4'd0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 8'd0, 4'd0, 4'd1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'(i), 4'(15 - i), 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'(i), 4'(i ^ 3), 1'b0);

    // write/read
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 4'(i), 8'(2 * (i + 1)), 4'd8, 4'd9, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 4'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd2, 4'd3, 1'b0);

    // bypass vs. registered path
    cyc(1'b1, 1'b1, 4'd5, 8'hA5, 4'd5, 4'd5, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd5, 4'd4, 1'b0);

    // zero register
    cyc(1'b1, 1'b1, 4'd0, 8'h3C, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 4'd5, 1'b0);

    // fill, then clr colliding with a write, writes lost while busy
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b1, 4'(i), 8'hFF, 4'(i), 4'd7, 1'b0);
    cyc(1'b1, 1'b1, 4'd7, 8'hFF, 4'd7, 4'd7, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b1, 1'b1, 4'(i), 8'($urandom), 4'd7, 4'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'(i), 4'd7, 1'b0);

    // reset mid-sweep at ptr=9
    cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'd1, 4'd2, 1'b0);
    cyc(1'b0, 1'b1, 4'd3, 8'h77, 4'd3, 4'd3, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b1, 1'b0, 4'd0, 8'd0, 4'(i), 4'd3, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) >= 2), ($urandom_range(0, 1) == 1), 4'($urandom),
          8'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 99) < 3));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
